// File: rtl/router_pkt_receiver.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_receiver
// Purpose  : Drains one router output port and parses header/payload/parity
//            packets; payload goes out on a ready/valid stream. Optional
//            mid-packet idle timeout enabled with `define RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_receiver #(
    parameter logic [1:0] PORT_ID        = 2'd0,
    parameter int         CNT_W          = 8,
    parameter int         TIMEOUT_CYCLES = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    output logic             read_enb,
    output logic [7:0]       pld_data,
    output logic             pld_valid,
    output logic             pld_last,
    input  logic             pld_ready,
    output logic             hdr_valid,
    output logic [1:0]       rx_addr,
    output logic [5:0]       rx_len,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_PLD = 2'd1,
        S_PAR = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_inflight;
    logic [1:0] r_buf_cnt;
    logic [7:0] r_buf_data [2];
    logic       r_buf_last [2];
    logic [7:0] r_parity;
    logic [5:0] r_remaining;

    logic       w_byte_in;
    logic [1:0] w_occ;
    logic       w_push;
    logic       w_pop;
    logic       w_last;
    logic       w_par_err;
    logic       w_addr_err;
    logic       w_timeout;

    // Occupancy counts the byte already on its way so the buffer can never overflow.
    assign w_byte_in  = r_inflight;
    assign w_occ      = r_buf_cnt + {1'b0, r_inflight};
    assign read_enb   = vld_out & ~reset & (w_occ < 2'd2);

    assign pld_valid  = (r_buf_cnt != 2'd0);
    assign pld_data   = r_buf_data[0];
    assign pld_last   = r_buf_last[0] & pld_valid;

    assign w_push     = w_byte_in && (r_state == S_PLD);
    assign w_pop      = pld_valid & pld_ready;
    assign w_last     = (r_remaining == 6'd1);
    assign w_par_err  = (data_out != r_parity);
    assign w_addr_err = (rx_addr != PORT_ID);

`ifdef RX_TIMEOUT_EN
    localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_IDLE_W-1:0] r_idle;

    assign w_timeout = (r_state != S_HDR) && !w_byte_in
                       && (r_idle == c_IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (w_byte_in || (r_state == S_HDR) || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + c_IDLE_W'(1);
        end
    end
`else
    // Timeout disabled: the parameter is referenced only to keep it visible.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_HDR;
        end else if (w_byte_in) begin
            case (r_state)
                S_HDR:   w_state_nxt = (data_out[7:2] == 6'd0) ? S_PAR : S_PLD;
                S_PLD:   w_state_nxt = w_last ? S_PAR : S_PLD;
                S_PAR:   w_state_nxt = S_HDR;
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight  <= 1'b0;
            r_parity    <= 8'd0;
            r_remaining <= 6'd0;
            hdr_valid   <= 1'b0;
            rx_addr     <= 2'd0;
            rx_len      <= 6'd0;
            pkt_done    <= 1'b0;
            parity_err  <= 1'b0;
            addr_err    <= 1'b0;
            good_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            r_inflight <= read_enb;
            hdr_valid  <= 1'b0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            if (w_timeout) begin
                pkt_done   <= 1'b1;
                parity_err <= 1'b1;
                r_parity   <= 8'd0;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end else if (w_byte_in) begin
                case (r_state)
                    S_HDR: begin
                        rx_addr     <= data_out[1:0];
                        rx_len      <= data_out[7:2];
                        r_remaining <= data_out[7:2];
                        r_parity    <= data_out;
                        hdr_valid   <= 1'b1;
                    end
                    S_PLD: begin
                        r_parity    <= r_parity ^ data_out;
                        r_remaining <= r_remaining - 6'd1;
                    end
                    S_PAR: begin
                        pkt_done   <= 1'b1;
                        parity_err <= w_par_err;
                        addr_err   <= w_addr_err;
                        if (w_par_err || w_addr_err) begin
                            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                        end else begin
                            if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Two-entry buffer; the head is always entry 0 and a pop shifts entry 1 down.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf_cnt     <= 2'd0;
            r_buf_data[0] <= 8'd0;
            r_buf_data[1] <= 8'd0;
            r_buf_last[0] <= 1'b0;
            r_buf_last[1] <= 1'b0;
        end else if (w_timeout) begin
            r_buf_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_buf_data[r_buf_cnt[0]] <= data_out;
                    r_buf_last[r_buf_cnt[0]] <= w_last;
                    r_buf_cnt                <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf_data[0] <= r_buf_data[1];
                    r_buf_last[0] <= r_buf_last[1];
                    r_buf_cnt     <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_buf_cnt == 2'd1) begin
                        r_buf_data[0] <= data_out;
                        r_buf_last[0] <= w_last;
                    end else begin
                        r_buf_data[0] <= r_buf_data[1];
                        r_buf_last[0] <= r_buf_last[1];
                        r_buf_data[1] <= data_out;
                        r_buf_last[1] <= w_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_receiver
// Purpose  : Directed self-checking bench for router_pkt_receiver (PORT_ID=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_receiver;

    localparam int c_CNT_W = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               vld_out = 1'b0;
    logic [7:0]         data_out = 8'd0;
    logic               read_enb;
    logic [7:0]         pld_data;
    logic               pld_valid;
    logic               pld_last;
    logic               pld_ready = 1'b0;
    logic               hdr_valid;
    logic [1:0]         rx_addr;
    logic [5:0]         rx_len;
    logic               pkt_done;
    logic               parity_err;
    logic               addr_err;
    logic [c_CNT_W-1:0] good_cnt;
    logic [c_CNT_W-1:0] err_cnt;

    router_pkt_receiver #(
        .PORT_ID        (2'd2),
        .CNT_W          (c_CNT_W),
        .TIMEOUT_CYCLES (30)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .pld_data   (pld_data),
        .pld_valid  (pld_valid),
        .pld_last   (pld_last),
        .pld_ready  (pld_ready),
        .hdr_valid  (hdr_valid),
        .rx_addr    (rx_addr),
        .rx_len     (rx_len),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .good_cnt   (good_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] src_q [$];
    logic [8:0] exp_q [$];
    logic [8:0] rx_q  [$];
    logic [7:0] hdr_log  [$];
    logic [1:0] done_log [$];
    logic       src_en     = 1'b1;
    logic       ready_mode = 1'b0;
    logic       fire_s     = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Router FIFO model: a read at a rising edge shows its byte on the following half cycle.
    always @(posedge clock) fire_s = read_enb && vld_out;

    always @(negedge clock) begin
        if (reset) begin
            src_q.delete();
        end else if (fire_s) begin
            data_out = src_q.pop_front();
        end
        vld_out = src_en && (src_q.size() != 0);
        pld_ready = ready_mode ? ~pld_ready : 1'b1;
        if (pld_valid && pld_ready) rx_q.push_back({pld_last, pld_data});
        if (hdr_valid) hdr_log.push_back({rx_len, rx_addr});
        if (pkt_done) done_log.push_back({parity_err, addr_err});
    end

    task automatic clear_logs();
        exp_q.delete();
        rx_q.delete();
        hdr_log.delete();
        done_log.delete();
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base, input logic bad_par);
        int         len;
        logic [7:0] par;
        logic [7:0] b;
        len = int'(hdr[7:2]);
        par = hdr;
        src_q.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            src_q.push_back(b);
            par = par ^ b;
            exp_q.push_back({(i == len - 1), b});
        end
        src_q.push_back(bad_par ? ~par : par);
    endtask

    task automatic wait_pkts(input int n);
        int cyc;
        cyc = 0;
        while (done_log.size() < n && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        repeat (12) @(negedge clock);
        check("pkt_done_count", done_log.size(), n);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_byte"}, (i < rx_q.size()) ? {23'd0, rx_q[i]} : 32'hDEAD, {23'd0, exp_q[i]});
        end
    endtask

    function automatic logic [7:0] hdr_at(input int i);
        return (i < hdr_log.size()) ? hdr_log[i] : 8'hFF;
    endfunction

    function automatic logic [1:0] done_at(input int i);
        return (i < done_log.size()) ? done_log[i] : 2'b11;
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        check("rst_outputs", {pld_valid, pld_last, hdr_valid, pkt_done, parity_err, addr_err, read_enb}, 7'd0);
        check("rst_counts", {good_cnt, err_cnt, rx_len, rx_addr, pld_data}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Good packet, length 8, address 2
        clear_logs();
        send_pkt(8'h22, 8'h10, 1'b0);
        wait_pkts(1);
        check("t1_hdr", hdr_at(0), {6'd8, 2'd2});
        check("t1_done", done_at(0), 2'b00);
        check_stream("t1");
        check("t1_good", good_cnt, 1);
        check("t1_err", err_cnt, 0);

        // Corrupted parity, length 5
        clear_logs();
        send_pkt(8'h16, 8'hA0, 1'b1);
        wait_pkts(1);
        check("t2_hdr", hdr_at(0), {6'd5, 2'd2});
        check("t2_done", done_at(0), 2'b10);
        check_stream("t2");
        check("t2_good", good_cnt, 1);
        check("t2_err", err_cnt, 1);

        // Zero-length packet to the wrong address
        clear_logs();
        send_pkt(8'h01, 8'h00, 1'b0);
        wait_pkts(1);
        check("t3_hdr", hdr_at(0), {6'd0, 2'd1});
        check("t3_done", done_at(0), 2'b01);
        check("t3_no_payload", rx_q.size(), 0);
        check("t3_err", err_cnt, 2);

        // Back-to-back packets with a stuttering sink
        clear_logs();
        ready_mode = 1'b1;
        send_pkt(8'h22, 8'h40, 1'b0);
        send_pkt(8'h16, 8'h80, 1'b0);
        wait_pkts(2);
        check("t4_done0", done_at(0), 2'b00);
        check("t4_done1", done_at(1), 2'b00);
        check_stream("t4");
        check("t4_good", good_cnt, 3);
        ready_mode = 1'b0;

        // Reset after three of eight payload bytes
        clear_logs();
        src_q.push_back(8'h22);
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        for (int c = 0; c < 100 && rx_q.size() < 3; c++) @(negedge clock);
        check("t5_partial", rx_q.size(), 3);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_outputs", {pld_valid, pld_last, hdr_valid, pkt_done, parity_err, addr_err, read_enb}, 7'd0);
        check("t5_rst_counts", {good_cnt, err_cnt, rx_len, rx_addr}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clear_logs();
        send_pkt(8'h0E, 8'h30, 1'b0);
        wait_pkts(1);
        check("t5_hdr", hdr_at(0), {6'd3, 2'd2});
        check("t5_done", done_at(0), 2'b00);
        check_stream("t5");
        check("t5_good", good_cnt, 1);

`ifdef RX_TIMEOUT_EN
        // Source goes quiet mid-payload
        clear_logs();
        src_q.push_back(8'h22);
        src_q.push_back(8'h55);
        src_q.push_back(8'h66);
        src_q.push_back(8'h77);
        wait_pkts(1);
        check("t6_done", done_at(0), 2'b10);
        check("t6_err", err_cnt, 1);
        check("t6_empty", pld_valid, 1'b0);
        clear_logs();
        send_pkt(8'h0E, 8'hC0, 1'b0);
        wait_pkts(1);
        check("t6_hdr", hdr_at(0), {6'd3, 2'd2});
        check_stream("t6");
        check("t6_good", good_cnt, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
